// File: rtl/mem_read_arbiter_pkg.sv
// Shared types and constants for the memory read-channel arbiter.
package mem_read_arbiter_pkg;

  // Default widths used as parameter defaults by the arbiter.
  localparam int unsigned DefNumReq   = 2;
  localparam int unsigned DefAddrWdth = 4;
  localparam int unsigned DefDataWdth = 32;
  localparam int unsigned DefRespWdth = 1;
  localparam int unsigned DefTimeout  = 64;

  // Read response codes (per bit of the response field).
  localparam logic RespOkay  = 1'b1;
  localparam logic RespError = 1'b0;

  // Arbiter FSM state encoding.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAddr   = 2'd1,
    StData   = 2'd2,
    StToResp = 2'd3
  } arb_state_e;

  // Increment an index modulo n.
  function automatic int unsigned wrap_inc(input int unsigned cur, input int unsigned n);
    return ((cur + 1) >= n) ? 0 : (cur + 1);
  endfunction

endpackage

// File: rtl/mem_read_arbiter_rr_pick.sv
// Combinational round-robin picker: first request at or after the pointer, wrapping.
module mem_read_arbiter_rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IdxW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IdxW-1:0]    i_ptr,
  output logic               o_any,
  output logic [IdxW-1:0]    o_idx
);

  int unsigned w_dist;
  int unsigned w_best;

  // Choose the requester with the smallest forward distance from the pointer.
  always_comb begin
    o_any  = 1'b0;
    o_idx  = '0;
    w_dist = 0;
    w_best = NUM_REQ;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_dist = (k + NUM_REQ - int'(i_ptr)) % NUM_REQ;
      if (i_req[k] && (w_dist < w_best)) begin
        w_best = w_dist;
        o_any  = 1'b1;
        o_idx  = IdxW'(k);
      end
    end
  end

endmodule

// File: rtl/mem_read_arbiter.sv
// Shares one memory read channel (single outstanding AR/R) among NUM_REQ requesters.
// Round-robin grant held from AR issue to R handshake; a watchdog converts a hung
// read into an ERROR response so the requester is never left waiting forever.
module mem_read_arbiter
  import mem_read_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ   = DefNumReq,
  parameter int unsigned ADDR_WDTH = DefAddrWdth,
  parameter int unsigned DATA_WDTH = DefDataWdth,
  parameter int unsigned RESP_WDTH = DefRespWdth,
  parameter int unsigned TIMEOUT   = DefTimeout,
  localparam int unsigned IdxW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           s_ar_valid,
  input  logic [NUM_REQ*ADDR_WDTH-1:0] s_ar_addr,
  output logic [NUM_REQ-1:0]           s_ar_ready,
  output logic [NUM_REQ-1:0]           s_r_valid,
  output logic [DATA_WDTH-1:0]         s_r_data,
  output logic [RESP_WDTH-1:0]         s_r_resp,
  input  logic [NUM_REQ-1:0]           s_r_ready,
  output logic                         m_ar_valid,
  output logic [ADDR_WDTH-1:0]         m_ar_addr,
  input  logic                         m_ar_ready,
  input  logic                         m_r_valid,
  input  logic [DATA_WDTH-1:0]         m_r_data,
  input  logic [RESP_WDTH-1:0]         m_r_resp,
  output logic                         m_r_ready,
  output logic                         busy,
  output logic [IdxW-1:0]              grant_id,
  output logic                         mem_timeout
);

  // Counter wide enough to reach TIMEOUT; saturates at all-ones.
  localparam int unsigned WdW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_e           r_state;
  logic [IdxW-1:0]      r_rr_ptr;
  logic [IdxW-1:0]      r_grant_id;
  logic [ADDR_WDTH-1:0] r_addr;
  logic [WdW-1:0]       r_wd_cnt;
  logic                 r_mem_timeout;

  logic                 w_pick_any;
  logic [IdxW-1:0]      w_pick_idx;
  logic [ADDR_WDTH-1:0] w_pick_addr;
  logic [NUM_REQ-1:0]   w_onehot;
  logic                 w_req_rdy;
  logic                 w_r_hs;
  logic                 w_wd_expire;
  logic [IdxW-1:0]      w_next_ptr;

  mem_read_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .i_req (s_ar_valid),
    .i_ptr (r_rr_ptr),
    .o_any (w_pick_any),
    .o_idx (w_pick_idx)
  );

  // Select the address of the requester the picker chose.
  always_comb begin
    w_pick_addr = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (w_pick_idx == IdxW'(k)) begin
        w_pick_addr = s_ar_addr[k*ADDR_WDTH +: ADDR_WDTH];
      end
    end
  end

  assign w_onehot    = NUM_REQ'(1) << r_grant_id;
  assign w_req_rdy   = s_r_ready[r_grant_id];
  assign w_r_hs      = (r_state == StData) && m_r_valid && w_req_rdy;
  // Expiry only matters when no handshake happens in the same cycle.
  assign w_wd_expire = (TIMEOUT != 0) && (r_wd_cnt == WdW'(TIMEOUT - 1));
  assign w_next_ptr  = IdxW'(wrap_inc(int'(r_grant_id), NUM_REQ));

  // Arbiter FSM with grant, address, watchdog and sticky timeout registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_rr_ptr      <= '0;
      r_grant_id    <= '0;
      r_addr        <= '0;
      r_wd_cnt      <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_pick_any) begin
            r_grant_id <= w_pick_idx;
            r_addr     <= w_pick_addr;
            r_state    <= StAddr;
          end
        end
        StAddr: begin
          if (m_ar_ready) begin
            r_wd_cnt <= '0;
            r_state  <= StData;
          end
        end
        StData: begin
          if (w_r_hs) begin
            r_rr_ptr <= w_next_ptr;
            r_state  <= StIdle;
          end else begin
            if (!(&r_wd_cnt)) begin
              r_wd_cnt <= r_wd_cnt + WdW'(1);
            end
            if (w_wd_expire) begin
              r_mem_timeout <= 1'b1;
              r_state       <= StToResp;
            end
          end
        end
        StToResp: begin
          if (w_req_rdy) begin
            r_rr_ptr <= w_next_ptr;
            r_state  <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Route channel signals to/from the granted requester only.
  always_comb begin
    s_ar_ready = '0;
    s_r_valid  = '0;
    s_r_data   = '0;
    s_r_resp   = '0;
    m_ar_valid = 1'b0;
    m_ar_addr  = '0;
    m_r_ready  = 1'b0;
    unique case (r_state)
      StAddr: begin
        m_ar_valid = 1'b1;
        m_ar_addr  = r_addr;
        if (m_ar_ready) begin
          s_ar_ready = w_onehot;
        end
      end
      StData: begin
        m_r_ready = w_req_rdy;
        s_r_data  = m_r_data;
        s_r_resp  = m_r_resp;
        if (m_r_valid) begin
          s_r_valid = w_onehot;
        end
      end
      StToResp: begin
        s_r_valid = w_onehot;
        s_r_resp  = {RESP_WDTH{RespError}};
        s_r_data  = '0;
      end
      default: ;
    endcase
  end

  assign busy        = (r_state != StIdle);
  assign grant_id    = r_grant_id;
  assign mem_timeout = r_mem_timeout;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Self-checking bench for mem_read_arbiter: directed scenarios plus random reads.
module tb_mem_read_arbiter;
  import mem_read_arbiter_pkg::*;

  localparam int NR = 2;
  localparam int AW = 4;
  localparam int DW = 32;

  logic             clk;
  logic             rst_n;
  logic [NR-1:0]    s_ar_valid;
  logic [NR*AW-1:0] s_ar_addr;
  logic [NR-1:0]    s_ar_ready;
  logic [NR-1:0]    s_r_valid;
  logic [DW-1:0]    s_r_data;
  logic [0:0]       s_r_resp;
  logic [NR-1:0]    s_r_ready;
  logic             m_ar_valid;
  logic [AW-1:0]    m_ar_addr;
  logic             m_ar_ready;
  logic             m_r_valid;
  logic [DW-1:0]    m_r_data;
  logic [0:0]       m_r_resp;
  logic             m_r_ready;
  logic             busy;
  logic [0:0]       grant_id;
  logic             mem_timeout;

  int n_asserts = 0;
  int n_fail    = 0;
  int mdl_ptr   = 0;  // requester with highest priority next round
  int mdl_to    = 0;  // expected sticky timeout flag

  mem_read_arbiter #(
    .NUM_REQ   (NR),
    .ADDR_WDTH (AW),
    .DATA_WDTH (DW),
    .RESP_WDTH (1),
    .TIMEOUT   (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_ar_valid  (s_ar_valid),
    .s_ar_addr   (s_ar_addr),
    .s_ar_ready  (s_ar_ready),
    .s_r_valid   (s_r_valid),
    .s_r_data    (s_r_data),
    .s_r_resp    (s_r_resp),
    .s_r_ready   (s_r_ready),
    .m_ar_valid  (m_ar_valid),
    .m_ar_addr   (m_ar_addr),
    .m_ar_ready  (m_ar_ready),
    .m_r_valid   (m_r_valid),
    .m_r_data    (m_r_data),
    .m_r_resp    (m_r_resp),
    .m_r_ready   (m_r_ready),
    .busy        (busy),
    .grant_id    (grant_id),
    .mem_timeout (mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration rule: first requester at or after ptr, wrapping.
  function automatic int pick(input logic [NR-1:0] req, input int ptr);
    int r;
    r = -1;
    for (int i = 0; i < NR; i++) begin
      if (r < 0 && req[(ptr + i) % NR]) r = (ptr + i) % NR;
    end
    return r;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_ar_ready"}, s_ar_ready, 0);
    chk({tag, "_s_r_valid"}, s_r_valid, 0);
    chk({tag, "_s_r_data"}, s_r_data, 0);
    chk({tag, "_s_r_resp"}, s_r_resp, 0);
    chk({tag, "_m_ar_valid"}, m_ar_valid, 0);
    chk({tag, "_m_ar_addr"}, m_ar_addr, 0);
    chk({tag, "_m_r_ready"}, m_r_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_grant_id"}, grant_id, 0);
    chk({tag, "_mem_timeout"}, mem_timeout, 0);
  endtask

  // One complete read starting in IDLE with requests already driven.
  task automatic run_read(input int ard, input int rd, input int rdyd, input logic [31:0] data,
                          input logic resp, input bit drop, output int g);
    logic [AW-1:0] a;
    g = pick(s_ar_valid, mdl_ptr);
    if (g < 0) begin
      n_asserts++;
      n_fail++;
      $error("FAIL run_read_noreq: observed none expected a request");
      return;
    end
    a = s_ar_addr[g*AW +: AW];
    #1;
    chk("idle_ar_valid", m_ar_valid, 0);
    chk("idle_busy", busy, 0);
    tick();
    m_ar_ready = 1'b0;
    for (int i = 0; i < ard; i++) begin
      #1;
      chk("addr_ar_valid", m_ar_valid, 1);
      chk("addr_ar_addr", m_ar_addr, a);
      chk("addr_ar_ready_wait", s_ar_ready, 0);
      chk("addr_grant", grant_id, g);
      tick();
    end
    m_ar_ready = 1'b1;
    #1;
    chk("addr_ar_valid", m_ar_valid, 1);
    chk("addr_ar_addr", m_ar_addr, a);
    chk("addr_ar_ready", s_ar_ready, 1 << g);
    chk("addr_grant", grant_id, g);
    chk("addr_busy", busy, 1);
    chk("addr_r_ready", m_r_ready, 0);
    tick();
    m_ar_ready = 1'b0;
    if (drop) s_ar_valid[g] = 1'b0;
    s_r_ready = NR'($urandom);
    s_r_ready[g] = 1'b1;
    m_r_valid = 1'b0;
    for (int i = 0; i < rd; i++) begin
      #1;
      chk("data_r_valid_wait", s_r_valid, 0);
      chk("data_m_r_ready", m_r_ready, 1);
      chk("data_ar_valid", m_ar_valid, 0);
      chk("data_ar_ready", s_ar_ready, 0);
      tick();
    end
    m_r_valid = 1'b1;
    m_r_data  = data;
    m_r_resp  = resp;
    s_r_ready[g] = 1'b0;
    for (int i = 0; i < rdyd; i++) begin
      #1;
      chk("bp_r_valid", s_r_valid, 1 << g);
      chk("bp_m_r_ready", m_r_ready, 0);
      chk("bp_r_data", s_r_data, data);
      tick();
    end
    s_r_ready[g] = 1'b1;
    #1;
    chk("hs_r_valid", s_r_valid, 1 << g);
    chk("hs_m_r_ready", m_r_ready, 1);
    chk("hs_r_data", s_r_data, data);
    chk("hs_r_resp", s_r_resp, resp);
    tick();
    m_r_valid = 1'b0;
    s_r_ready = '0;
    mdl_ptr = (g + 1) % NR;
    #1;
    chk("done_busy", busy, 0);
    chk("done_r_valid", s_r_valid, 0);
    chk("done_timeout", mem_timeout, mdl_to);
  endtask

  initial begin
    int g;
    int order[4];
    rst_n = 1'b0;
    s_ar_valid = '0;
    s_ar_addr  = '0;
    s_r_ready  = '0;
    m_ar_ready = 1'b0;
    m_r_valid  = 1'b0;
    m_r_data   = '0;
    m_r_resp   = '0;
    #1;
    chk_all_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;

    // 1: single read from requester 0
    s_ar_valid = 2'b01;
    s_ar_addr  = 8'h03;
    run_read(2, 1, 0, 32'hDEADBEEF, RespOkay, 1'b1, g);
    chk("single_grant", g, 0);

    // 2: contention from reset alternates grants
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mdl_ptr = 0;
    s_ar_valid = 2'b11;
    s_ar_addr  = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      run_read(1, 1, 1, $urandom, RespOkay, 1'b0, order[i]);
    end
    chk("cont_order0", order[0], 0);
    chk("cont_order1", order[1], 1);
    chk("cont_order2", order[2], 0);
    chk("cont_order3", order[3], 1);

    // 3: backpressure on requester 1
    s_ar_valid = 2'b10;
    s_ar_addr  = 8'h70;
    run_read(0, 0, 5, 32'h1234_5678, RespOkay, 1'b1, g);
    chk("bp_grant", g, 1);

    // 6: error response forwarded, no timeout
    s_ar_valid = 2'b01;
    s_ar_addr  = 8'h0E;
    run_read(0, 1, 0, 32'hCAFE_F00D, RespError, 1'b1, g);
    // handshake on the watchdog's last cycle wins
    s_ar_valid = 2'b01;
    run_read(0, 7, 0, 32'h0BAD_BEEF, RespError, 1'b1, g);
    s_ar_valid = 2'b10;
    run_read(0, 0, 7, 32'h5555_AAAA, RespOkay, 1'b1, g);

    // 4: watchdog expiry
    s_ar_valid = 2'b10;
    s_ar_addr  = 8'h90;
    g = pick(s_ar_valid, mdl_ptr);
    #1;
    tick();
    m_ar_ready = 1'b1;
    #1;
    chk("wd_ar_ready", s_ar_ready, 1 << g);
    tick();
    m_ar_ready = 1'b0;
    s_ar_valid = '0;
    m_r_data   = 32'hFFFF_FFFF;
    m_r_resp   = 1'b1;
    s_r_ready  = '0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("wd_wait_r_valid", s_r_valid, 0);
      chk("wd_wait_timeout", mem_timeout, 0);
      chk("wd_wait_busy", busy, 1);
      tick();
    end
    #1;
    chk("wd_r_valid", s_r_valid, 1 << g);
    chk("wd_r_resp", s_r_resp, 0);
    chk("wd_r_data", s_r_data, 0);
    chk("wd_m_r_ready", m_r_ready, 0);
    chk("wd_timeout", mem_timeout, 1);
    tick();
    #1;
    chk("wd_hold_r_valid", s_r_valid, 1 << g);
    s_r_ready[g] = 1'b1;
    tick();
    s_r_ready = '0;
    mdl_ptr = (g + 1) % NR;
    mdl_to  = 1;
    #1;
    chk("wd_done_busy", busy, 0);
    chk("wd_done_timeout", mem_timeout, 1);

    // 5: reset in the middle of DATA
    s_ar_valid = 2'b01;
    s_ar_addr  = 8'h04;
    #1;
    tick();
    m_ar_ready = 1'b1;
    tick();
    m_ar_ready = 1'b0;
    m_r_valid  = 1'b1;
    m_r_data   = 32'hA5A5_A5A5;
    m_r_resp   = 1'b1;
    s_r_ready  = '0;
    #1;
    chk("mid_r_valid", s_r_valid, 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    tick();
    m_r_valid  = 1'b0;
    s_ar_valid = 2'b10;
    s_ar_addr  = 8'hC0;
    rst_n   = 1'b1;
    mdl_ptr = 0;
    mdl_to  = 0;
    run_read(0, 0, 0, 32'h0F0F_0F0F, RespOkay, 1'b1, g);
    chk("postrst_grant", g, 1);

    // Random reads checked against the arbitration model
    for (int n = 0; n < 40; n++) begin
      if (s_ar_valid == '0) s_ar_valid = NR'($urandom_range(1, 3));
      s_ar_addr = 8'($urandom);
      run_read($urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3), $urandom,
               1'($urandom), 1'($urandom), g);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
